// File: rtl/fetch_unit.sv
// Instruction fetch / PC stage: fetches one instruction at a time over a
// ready-handshaked memory port and selects the next PC after execute acks.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0080
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [5:0]  op,
    output logic [5:0]  funct,
    output logic [4:0]  mf,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic        instr_ack,
    input  logic        branch,
    input  logic        branch_eq,
    input  logic        branch_leq,
    input  logic        jump,
    input  logic        jump_reg,
    input  logic        jal,
    input  logic        sys,
    input  logic        exce_ret,
    input  logic        alu_zero,
    input  logic [31:0] rs_value,
    input  logic        halt,
    output logic [31:0] epc,
    output logic        exl
);

    typedef enum logic [1:0] {FETCH, VALID, HALT} state_t;

    state_t      state, state_n;
    logic [31:0] pc_n, instr_n, epc_n;
    logic [31:0] npc, npc_epc;
    logic        npc_exl;
    logic        valid_n, exl_n, req_n;
    logic        taken;
    logic [31:0] br_off;

    assign imem_addr = pc;
    assign op        = instr[31:26];
    assign funct     = instr[5:0];
    assign mf        = instr[25:21];

    // Branch condition and sign-extended word offset.
    always_comb begin
        br_off = {{14{instr[15]}}, instr[15:0], 2'b00};
        if (branch_eq)
            taken = alu_zero;
        else if (branch_leq)
            taken = rs_value[31] || (rs_value == 32'd0);
        else
            taken = !alu_zero;
        taken = taken && branch;
    end

    // Next-PC selection; exception return outranks syscall entry and all jumps.
    // jal is decoded as a jump too, so only the jump flag steers the PC here.
    always_comb begin
        npc     = pc_plus4;
        npc_epc = epc;
        npc_exl = exl;
        if (exce_ret) begin
            npc     = epc;
            npc_exl = 1'b0;
        end else if (sys && !exl) begin
            npc_epc = pc_plus4;
            npc     = EXC_VECTOR;
            npc_exl = 1'b1;
        end else if (sys) begin
            npc = pc_plus4;
        end else if (jump_reg) begin
            npc = {rs_value[31:2], 2'b00};
        end else if (jump) begin
            npc = {pc_plus4[31:28], instr[25:0], 2'b00};
        end else if (taken) begin
            npc = pc_plus4 + br_off;
        end
    end

    // FSM next-state and register next values.
    always_comb begin
        state_n = state;
        pc_n    = pc;
        instr_n = instr;
        valid_n = instr_valid;
        epc_n   = epc;
        exl_n   = exl;
        case (state)
            FETCH: begin
                if (imem_req && imem_ready) begin
                    instr_n = imem_rdata;
                    valid_n = 1'b1;
                    state_n = VALID;
                end
            end
            VALID: begin
                if (instr_ack) begin
                    pc_n    = npc;
                    epc_n   = npc_epc;
                    exl_n   = npc_exl;
                    valid_n = 1'b0;
                    state_n = halt ? HALT : FETCH;
                end
            end
            HALT: begin
                if (!halt)
                    state_n = FETCH;
            end
            default: state_n = FETCH;
        endcase
        req_n = (state_n == FETCH);
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            pc_plus4    <= RESET_PC + 32'd4;
            instr       <= 32'd0;
            instr_valid <= 1'b0;
            epc         <= 32'd0;
            exl         <= 1'b0;
            imem_req    <= 1'b0;
        end else begin
            state       <= state_n;
            pc          <= pc_n;
            pc_plus4    <= pc_n + 32'd4;
            instr       <= instr_n;
            instr_valid <= valid_n;
            epc         <= epc_n;
            exl         <= exl_n;
            imem_req    <= req_n;
        end
    end

endmodule
